// File: rtl/morse_pkg.sv
// Shared definitions for the Morse keyer.
//   state_t     : keyer FSM states
//   *_UNITS     : durations in dot units
//   elem_units  : MARK length for one element (0 = dot, 1 = dash)
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MARK,
        SPACE,
        GAP
    } state_t;

    localparam logic [2:0] DOT_UNITS        = 3'd1;
    localparam logic [2:0] DASH_UNITS       = 3'd3;
    localparam logic [2:0] ELEM_GAP_UNITS   = 3'd1;
    localparam logic [2:0] CHAR_GAP_UNITS   = 3'd3;
    localparam logic [2:0] WORD_EXTRA_UNITS = 3'd4;

    function automatic logic [2:0] elem_units(input logic is_dash);
        return is_dash ? DASH_UNITS : DOT_UNITS;
    endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational ASCII -> Morse code table.
//   char : ASCII input (A-Z and a-z map identically, 0-9 supported)
//   len  : number of elements, 0 for anything unsupported
//   pat  : elements left-aligned, pat[4] first, 0 = dot, 1 = dash
//   word : set for space (0x20), the word separator
module morse_lut (
    input  logic [7:0] char,
    output logic [2:0] len,
    output logic [4:0] pat,
    output logic       word
);

    logic [7:0] uc;

    always_comb begin
        uc         = char;
        if (char >= 8'h61 && char <= 8'h7a)
            uc = char - 8'h20;
        word       = (char == 8'h20);
        {len, pat} = 8'h00;
        case (uc)
            "A": {len, pat} = {3'd2, 5'b01000};
            "B": {len, pat} = {3'd4, 5'b10000};
            "C": {len, pat} = {3'd4, 5'b10100};
            "D": {len, pat} = {3'd3, 5'b10000};
            "E": {len, pat} = {3'd1, 5'b00000};
            "F": {len, pat} = {3'd4, 5'b00100};
            "G": {len, pat} = {3'd3, 5'b11000};
            "H": {len, pat} = {3'd4, 5'b00000};
            "I": {len, pat} = {3'd2, 5'b00000};
            "J": {len, pat} = {3'd4, 5'b01110};
            "K": {len, pat} = {3'd3, 5'b10100};
            "L": {len, pat} = {3'd4, 5'b01000};
            "M": {len, pat} = {3'd2, 5'b11000};
            "N": {len, pat} = {3'd2, 5'b10000};
            "O": {len, pat} = {3'd3, 5'b11100};
            "P": {len, pat} = {3'd4, 5'b01100};
            "Q": {len, pat} = {3'd4, 5'b11010};
            "R": {len, pat} = {3'd3, 5'b01000};
            "S": {len, pat} = {3'd3, 5'b00000};
            "T": {len, pat} = {3'd1, 5'b10000};
            "U": {len, pat} = {3'd3, 5'b00100};
            "V": {len, pat} = {3'd4, 5'b00010};
            "W": {len, pat} = {3'd3, 5'b01100};
            "X": {len, pat} = {3'd4, 5'b10010};
            "Y": {len, pat} = {3'd4, 5'b10110};
            "Z": {len, pat} = {3'd4, 5'b11000};
            "0": {len, pat} = {3'd5, 5'b11111};
            "1": {len, pat} = {3'd5, 5'b01111};
            "2": {len, pat} = {3'd5, 5'b00111};
            "3": {len, pat} = {3'd5, 5'b00011};
            "4": {len, pat} = {3'd5, 5'b00001};
            "5": {len, pat} = {3'd5, 5'b00000};
            "6": {len, pat} = {3'd5, 5'b10000};
            "7": {len, pat} = {3'd5, 5'b11000};
            "8": {len, pat} = {3'd5, 5'b11100};
            "9": {len, pat} = {3'd5, 5'b11110};
            default: {len, pat} = 8'h00;
        endcase
    end

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: accepts one ASCII character at a time and keys it out with
// ITU timing (dot 1, dash 3, element gap 1, character gap 3, word gap 7 units).
//   clk_27MHz  : system clock
//   rst_n      : asynchronous active-low reset
//   char_valid : upstream character valid
//   char_data  : ASCII character
//   char_ready : keyer idle and able to accept a character
//   key_n      : registered active-low key, 0 = carrier on
//   busy       : FSM is not idle
module morse_keyer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 1620000
) (
    input  logic       clk_27MHz,
    input  logic       rst_n,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       char_ready,
    output logic       key_n,
    output logic       busy
);

    localparam int            CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CW-1:0] TC = CW'(UNIT_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] unit_cnt;
    logic [2:0]    units_rem;
    logic [7:0]    char_q;
    logic [4:0]    pat_q;
    logic [2:0]    len_q;

    logic [2:0]    lut_len;
    logic [4:0]    lut_pat;
    logic          lut_word;
    logic          tick;
    logic          last_unit;

    morse_lut u_lut (
        .char (char_q),
        .len  (lut_len),
        .pat  (lut_pat),
        .word (lut_word)
    );

    assign tick      = (unit_cnt == TC);
    assign last_unit = tick && (units_rem <= 3'd1);

    always_ff @(posedge clk_27MHz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            unit_cnt   <= '0;
            units_rem  <= '0;
            char_q     <= '0;
            pat_q      <= '0;
            len_q      <= '0;
            char_ready <= 1'b0;
            key_n      <= 1'b1;
            busy       <= 1'b0;
        end else begin
            // Timed states share the unit timebase; IDLE/LOAD override it.
            unit_cnt <= tick ? '0 : unit_cnt + 1'b1;
            if (tick && units_rem != 3'd0)
                units_rem <= units_rem - 1'b1;

            case (state)
                IDLE: begin
                    unit_cnt   <= '0;
                    units_rem  <= '0;
                    char_ready <= 1'b1;
                    busy       <= 1'b0;
                    key_n      <= 1'b1;
                    if (char_valid && char_ready) begin
                        char_q     <= char_data;
                        state      <= LOAD;
                        char_ready <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    pat_q    <= lut_pat;
                    len_q    <= lut_len;
                    unit_cnt <= '0;
                    if (lut_len != 3'd0) begin
                        state     <= MARK;
                        key_n     <= 1'b0;
                        units_rem <= elem_units(lut_pat[4]);
                    end else if (lut_word) begin
                        // Previous character already left 3 units of silence.
                        state     <= GAP;
                        units_rem <= WORD_EXTRA_UNITS;
                    end else begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        char_ready <= 1'b1;
                    end
                end
                MARK: begin
                    if (last_unit) begin
                        key_n <= 1'b1;
                        if (len_q == 3'd1) begin
                            state     <= GAP;
                            units_rem <= CHAR_GAP_UNITS;
                        end else begin
                            state     <= SPACE;
                            units_rem <= ELEM_GAP_UNITS;
                            // Shift early so the next element sits in pat_q[4]
                            // by the time SPACE hands back to MARK.
                            pat_q     <= {pat_q[3:0], 1'b0};
                        end
                    end
                end
                SPACE: begin
                    if (last_unit) begin
                        state     <= MARK;
                        key_n     <= 1'b0;
                        len_q     <= len_q - 1'b1;
                        units_rem <= elem_units(pat_q[4]);
                    end
                end
                GAP: begin
                    if (last_unit) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        char_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    key_n <= 1'b1;
                end
            endcase
        end
    end

endmodule
